// File: rtl/adder_pkg.sv
// Shared constants for the pipelined adder/accumulator.
// Mode encodings and the stage-1 sum width helper.
package adder_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_ACC = 1'b1;

  // SUM1_W = IN_W+1: stage 1 keeps the full carry of a+b so nothing is lost
  // before stage 2 widens it to OUT_W.
  function automatic int sum1_w(input int in_w);
    return in_w + 1;
  endfunction

endpackage

// File: rtl/adder_acc_pipe_sat_add.sv
// OUT_W-bit adder with carry-out; wraps by default, clamps to all-ones when
// ADDER_ACC_SAT_EN is defined.
module adder_sat_add #(
  parameter int OUT_W = 8
) (
  input  logic [OUT_W-1:0] base_i,
  input  logic [OUT_W-1:0] addend_i,
  output logic [OUT_W-1:0] sum_o,
  output logic             carry_o
);

  logic [OUT_W:0] full;

  always_comb begin
    full    = {1'b0, base_i} + {1'b0, addend_i};
    carry_o = full[OUT_W];
`ifdef ADDER_ACC_SAT_EN
    sum_o   = full[OUT_W] ? {OUT_W{1'b1}} : full[OUT_W-1:0];
`else
    sum_o   = full[OUT_W-1:0];
`endif
  end

endmodule

// File: rtl/adder_acc_pipe.sv
// Two-stage valid/ready adder with per-beat accumulate mode and overflow flag.
// Define ADDER_ACC_SAT_EN to saturate the accumulate path instead of wrapping.
module adder_acc_pipe
  import adder_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  a,
  input  logic [IN_W-1:0]  b,
  input  logic             mode,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  output logic [OUT_W-1:0] acc_q
);

  localparam int SUM1_W = sum1_w(IN_W);

  if (OUT_W < SUM1_W) begin : g_bad_width
    $error("adder_acc_pipe: OUT_W must be >= IN_W+1");
  end

  logic              s1_valid_q, s1_valid_d;
  logic [SUM1_W-1:0] s1_sum_q,   s1_sum_d;
  logic              s1_mode_q,  s1_mode_d;
  logic              s1_clr_q,   s1_clr_d;

  logic              out_valid_q, out_valid_d;
  logic [OUT_W-1:0]  out_data_q,  out_data_d;
  logic              out_ovf_q,   out_ovf_d;
  logic [OUT_W-1:0]  acc_d;

  logic              s2_adv, s1_adv, in_xfer, s2_load;
  logic [OUT_W-1:0]  add_base, add_sum;
  logic              add_carry;

  // No skid buffer: in_ready is combinational from out_ready.
  always_comb begin
    s2_adv   = !out_valid_q || out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    in_ready = s1_adv;
    in_xfer  = in_valid && s1_adv;
    s2_load  = s2_adv && s1_valid_q;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sum_d   = s1_sum_q;
    s1_mode_d  = s1_mode_q;
    s1_clr_d   = s1_clr_q;
    if (in_xfer) begin
      s1_valid_d = 1'b1;
      s1_sum_d   = SUM1_W'(a) + SUM1_W'(b);
      s1_mode_d  = mode;
      s1_clr_d   = clr;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // A zero base makes the shared adder produce the plain a+b result for MODE_ADD.
  always_comb begin
    add_base = (s1_mode_q == MODE_ACC && !s1_clr_q) ? acc_q : '0;
  end

  adder_sat_add #(
    .OUT_W (OUT_W)
  ) u_sat_add (
    .base_i   (add_base),
    .addend_i (OUT_W'(s1_sum_q)),
    .sum_o    (add_sum),
    .carry_o  (add_carry)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    acc_d       = acc_q;
    if (s2_load) begin
      out_valid_d = 1'b1;
      out_data_d  = add_sum;
      out_ovf_d   = (s1_mode_q == MODE_ACC) && add_carry;
      if (s1_mode_q == MODE_ACC) acc_d = add_sum;
    end else if (s2_adv) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_sum_q    <= '0;
      s1_mode_q   <= 1'b0;
      s1_clr_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      acc_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sum_q    <= s1_sum_d;
      s1_mode_q   <= s1_mode_d;
      s1_clr_q    <= s1_clr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      acc_q       <= acc_d;
    end
  end

  always_comb begin
    out_valid = out_valid_q;
    out_data  = out_data_q;
    out_ovf   = out_ovf_q;
  end

endmodule

// File: tb/tb_adder_acc_pipe.sv
// Scoreboard bench for adder_acc_pipe (IN_W=4, OUT_W=8).
module tb_adder_acc_pipe;

  localparam int IN_W  = 4;
  localparam int OUT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  a, b;
  logic             mode, clr;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_ovf;
  logic [OUT_W-1:0] acc_q;

  int errors = 0;
  int checks = 0;
  int n_acc  = 0;
  int n_pop  = 0;

  logic [OUT_W:0]   sb[$];
  logic [OUT_W-1:0] macc = '0;

  always #5 clk = ~clk;

  adder_acc_pipe #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .clr       (clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .acc_q     (acc_q)
  );

  // Scoreboard: model pushes on input transfer, compare on output transfer.
  always @(negedge clk) begin
    logic [OUT_W:0]   exp;
    logic [OUT_W:0]   full;
    logic [OUT_W-1:0] base;
    if (!rst) begin
      if (out_valid && out_ready) begin
        checks++;
        n_pop++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got ovf=%0b data=%02h, expected no beat", out_ovf, out_data);
        end else begin
          exp = sb.pop_front();
          if ({out_ovf, out_data} !== exp) begin
            errors++;
            $display("FAIL sb_data: got ovf=%0b data=%02h, expected ovf=%0b data=%02h",
                     out_ovf, out_data, exp[OUT_W], exp[OUT_W-1:0]);
          end
        end
      end
      if (in_valid && in_ready) begin
        n_acc++;
        if (mode == 1'b0) begin
          exp = (OUT_W+1)'(a) + (OUT_W+1)'(b);
        end else begin
          base = clr ? '0 : macc;
          full = {1'b0, base} + (OUT_W+1)'(a) + (OUT_W+1)'(b);
`ifdef ADDER_ACC_SAT_EN
          if (full[OUT_W]) full[OUT_W-1:0] = '1;
`endif
          exp  = full;
          macc = full[OUT_W-1:0];
        end
        sb.push_back(exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; a = 4'h3; b = 4'h4; mode = 1'b0; clr = 1'b0; out_ready = 1'b1;
    repeat (2) tick();
    checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL rst_out_valid: got %0b, expected 0", out_valid); end
    checks++; if (out_data !== 8'h00)   begin errors++; $display("FAIL rst_out_data: got %02h, expected 00", out_data); end
    checks++; if (acc_q !== 8'h00)      begin errors++; $display("FAIL rst_acc: got %02h, expected 00", acc_q); end
    checks++; if (out_ovf !== 1'b0)     begin errors++; $display("FAIL rst_ovf: got %0b, expected 0", out_ovf); end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1)    begin errors++; $display("FAIL rst_in_ready: got %0b, expected 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL rst_no_beat: got out_valid=%0b, expected 0", out_valid); end
  endtask

  task automatic test_add_latency();
    in_valid = 1'b1; a = 4'hF; b = 4'hF; mode = 1'b0; clr = 1'b0; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL add_early: got out_valid=%0b after 1 cycle, expected 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1)   begin errors++; $display("FAIL add_latency: got out_valid=%0b after 2 cycles, expected 1", out_valid); end
    checks++; if (out_data !== 8'h1E)   begin errors++; $display("FAIL add_data: got %02h, expected 1e", out_data); end
    checks++; if (out_ovf !== 1'b0)     begin errors++; $display("FAIL add_ovf: got %0b, expected 0", out_ovf); end
    checks++; if (acc_q !== macc)       begin errors++; $display("FAIL add_acc: got %02h, expected %02h", acc_q, macc); end
    tick();
  endtask

  task automatic test_acc_chain();
    logic [3:0] ta [3];
    logic [3:0] tb_[3];
    logic [7:0] te [3];
    ta[0] = 4'd3;  tb_[0] = 4'd4;  te[0] = 8'h07;
    ta[1] = 4'd5;  tb_[1] = 4'd6;  te[1] = 8'h12;
    ta[2] = 4'd15; tb_[2] = 4'd15; te[2] = 8'h30;
    out_ready = 1'b1; mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i < 3);
      if (i < 3) begin a = ta[i]; b = tb_[i]; clr = (i == 0); end
      tick();
      if (i >= 1 && i <= 3) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== te[i-1]) begin
          errors++;
          $display("FAIL acc_chain[%0d]: got valid=%0b data=%02h, expected valid=1 data=%02h",
                   i-1, out_valid, out_data, te[i-1]);
        end
      end
    end
    in_valid = 1'b0; clr = 1'b0;
    checks++; if (acc_q !== 8'h30)      begin errors++; $display("FAIL acc_final: got %02h, expected 30", acc_q); end
  endtask

  task automatic test_backpressure();
    logic [3:0] ta [4];
    logic [3:0] tb_[4];
    int s_acc, s_pop, budget;
    for (int i = 0; i < 4; i++) begin ta[i] = 4'(2*i+1); tb_[i] = 4'(2*i+2); end
    s_acc = n_acc; s_pop = n_pop;
    mode = 1'b0; clr = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = (n_acc - s_acc) < 4;
      if (in_valid) begin a = ta[n_acc - s_acc]; b = tb_[n_acc - s_acc]; end
      tick();
    end
    checks++; if (n_acc - s_acc != 2)   begin errors++; $display("FAIL bp_accepted: got %0d beats, expected 2", n_acc - s_acc); end
    checks++; if (in_ready !== 1'b0)    begin errors++; $display("FAIL bp_in_ready: got %0b, expected 0", in_ready); end
    out_ready = 1'b1;
    budget = 30;
    while ((n_pop - s_pop) < 4 && budget > 0) begin
      in_valid = (n_acc - s_acc) < 4;
      if (in_valid) begin a = ta[n_acc - s_acc]; b = tb_[n_acc - s_acc]; end
      tick();
      budget--;
    end
    in_valid = 1'b0;
    checks++; if (n_pop - s_pop != 4)   begin errors++; $display("FAIL bp_drain: got %0d results, expected 4", n_pop - s_pop); end
    repeat (2) tick();
  endtask

  task automatic test_overflow();
    logic [7:0] exp_d;
`ifdef ADDER_ACC_SAT_EN
    exp_d = 8'hFF;
`else
    exp_d = 8'h0E;
`endif
    out_ready = 1'b1; mode = 1'b1; a = 4'hF; b = 4'hF;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i < 9);
      clr = (i == 0);
      tick();
      if (i == 8) begin
        checks++; if (acc_q !== 8'hF0)  begin errors++; $display("FAIL ovf_preload: got acc %02h, expected f0", acc_q); end
      end
    end
    in_valid = 1'b0; clr = 1'b0;
    checks++; if (out_data !== exp_d)   begin errors++; $display("FAIL ovf_data: got %02h, expected %02h", out_data, exp_d); end
    checks++; if (out_ovf !== 1'b1)     begin errors++; $display("FAIL ovf_flag: got %0b, expected 1", out_ovf); end
    checks++; if (acc_q !== exp_d)      begin errors++; $display("FAIL ovf_acc: got %02h, expected %02h", acc_q, exp_d); end
    tick();
  endtask

  task automatic test_reset_midflight();
    int s_acc, budget, bad;
    s_acc = n_acc;
    out_ready = 1'b0; mode = 1'b1; clr = 1'b1; a = 4'd1; b = 4'd2;
    budget = 10;
    while ((n_acc - s_acc) < 2 && budget > 0) begin
      in_valid = 1'b1;
      tick();
      clr = 1'b0;
      budget--;
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || acc_q !== 8'h03) begin
      errors++;
      $display("FAIL mid_fill: got valid=%0b in_ready=%0b acc=%02h, expected 1 0 03", out_valid, in_ready, acc_q);
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL mid_out_valid: got %0b, expected 0", out_valid); end
    checks++; if (acc_q !== 8'h00)      begin errors++; $display("FAIL mid_acc: got %02h, expected 00", acc_q); end
    checks++; if (out_data !== 8'h00)   begin errors++; $display("FAIL mid_out_data: got %02h, expected 00", out_data); end
    sb.delete();
    macc = '0;
    #1 rst = 1'b0;
    out_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (out_valid !== 1'b0) bad++;
    end
    checks++; if (bad != 0)             begin errors++; $display("FAIL mid_stale: got %0d cycles with out_valid=1, expected 0", bad); end
    checks++; if (in_ready !== 1'b1)    begin errors++; $display("FAIL mid_in_ready: got %0b, expected 1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_add_latency();
    test_acc_chain();
    test_backpressure();
    test_overflow();
    test_reset_midflight();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d pending, expected 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
